mac_array: RTL
==============

MAC_ARRAY -- requirements
Module: mac_array

Interface
REQ-001 Parameter DATA_WIDTH, default 8: unsigned operand width per lane.
REQ-002 Parameter LANES, default 4: number of independent MAC lanes.
REQ-003 Parameter ACC_WIDTH, default 3*DATA_WIDTH: accumulator width per lane (>= 2*DATA_WIDTH).
REQ-004 Parameter VEC_LEN, default 8: beats per dot-product operation (>= 1).
REQ-005 clk  input  1  clock; rst_n  input  1  reset, asynchronous, active-low.
REQ-006 clr  input  1  synchronous clear, highest priority after rst_n.
REQ-007 in_valid  input  1  operand beat valid.
REQ-008 in_ready  output  1  block accepts beat when in_valid && in_ready.
REQ-009 a_vec  input  LANES*DATA_WIDTH  lane i operand A at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-010 b_vec  input  LANES*DATA_WIDTH  lane i operand B, same packing.
REQ-011 out_valid  output  1  result vector valid.
REQ-012 out_ready  input  1  consumer accepts result when out_valid && out_ready.
REQ-013 cout  output  LANES*ACC_WIDTH  lane i accumulator at [i*ACC_WIDTH +: ACC_WIDTH].
REQ-014 ovf  output  LANES  per-lane sticky overflow flag.

Function
REQ-015 FSM states IDLE, ACC, DRAIN, DONE; in_ready=1 in IDLE/ACC only; out_valid=1 in DONE only.
REQ-016 Two-stage pipeline: accepted beat's lane products (unsigned, 2*DATA_WIDTH, zero-extended) registered at accept edge; added into accumulators on following edge.
REQ-017 Beat counter, width $clog2(VEC_LEN+1), increments per accepted beat; cleared on leaving DONE and on clr.
REQ-018 IDLE -> ACC on accepted beat when VEC_LEN>1; IDLE -> DRAIN when VEC_LEN==1.
REQ-019 ACC -> DRAIN on accepting beat number VEC_LEN; in_valid low in ACC inserts bubble, no accumulate, state held.
REQ-020 DRAIN lasts exactly one cycle (final product added) then -> DONE; out_valid high second edge after last accept edge.
REQ-021 DONE: cout and ovf held stable while out_ready low; on out_valid && out_ready -> IDLE, accumulators, product regs and ovf cleared same edge.
REQ-022 Product register loads only on accepted beats; accumulators update only the cycle after an accepted beat.
REQ-023 cout continuously reflects accumulators (partial sums visible outside DONE; only meaningful when out_valid).
REQ-024 clr: state IDLE, accumulators, products, counter, ovf zeroed next edge; overrides any simultaneous handshake; a beat presented with clr is discarded.

Reset
REQ-025 rst_n low asynchronously forces IDLE, counter 0, all products 0, cout 0, ovf 0, out_valid 0; in_ready=1 after reset.
REQ-026 rst_n asserted mid-operation discards all partial results; first post-reset accepted beat starts a fresh operation.

Configuration
REQ-027 Macro MAC_ARRAY_SAT_EN defined: per-lane accumulate computed at ACC_WIDTH+1 bits; on carry-out lane clamps to all ones (2^ACC_WIDTH-1), stays clamped for rest of operation, ovf[i] set sticky until DONE exit/clr/reset.
REQ-028 Macro MAC_ARRAY_SAT_EN undefined: accumulation wraps modulo 2^ACC_WIDTH; ovf tied to 0.

Verification (LANES=4, DATA_WIDTH=8, VEC_LEN=4 unless stated)
REQ-029 Reset release -> in_ready=1, out_valid=0, cout=0, ovf=0.
REQ-030 4 back-to-back beats, A lanes all 3, B lanes {1,2,3,4} -> cout lanes {12,24,36,48}, out_valid 2 cycles after 4th accept edge.
REQ-031 Same operands, in_valid low for 3 cycles between beats 2 and 3 -> identical cout {12,24,36,48}, no extra accumulation.
REQ-032 out_ready low 5 cycles in DONE -> cout stable, in_ready=0, ignored in_valid beats; out_ready high -> IDLE, cout 0 next cycle.
REQ-033 clr after 2 accepted beats of A=5,B=5, then full op A=1,B=1 -> all lanes 4, no residue of 50.
REQ-034 ACC_WIDTH=16, VEC_LEN=2, A=B=255 -> with MAC_ARRAY_SAT_EN cout lanes 65535, ovf=4'hF; without, cout lanes 64514, ovf=0.

Source files
------------

// File: rtl/mac_array.sv
// mac_array: LANES-wide unsigned multiply-accumulate engine computing VEC_LEN-beat dot products.
//
// Each accepted beat multiplies lane operands a_vec/b_vec into a product register. On the
// following edge the products are added into the per-lane accumulators. Once the last beat
// has been accepted, one DRAIN cycle folds in the final product. The block then presents
// the result in DONE until it is consumed.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   clr             synchronous clear (state, accumulators, products, counter, ovf)
//   in_valid/ready  operand beat handshake; a_vec/b_vec lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   out_valid/ready result handshake; cout lane i at [i*ACC_WIDTH +: ACC_WIDTH]
//   ovf             per-lane sticky saturation flag
//
// Configuration:
//   MAC_ARRAY_SAT_EN  defined: lanes clamp to all ones on accumulator carry-out and set ovf.
//                     undefined: accumulators wrap modulo 2^ACC_WIDTH and ovf stays 0.
module mac_array #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned LANES      = 4,
    parameter int unsigned ACC_WIDTH  = 3 * DATA_WIDTH,
    parameter int unsigned VEC_LEN    = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clr,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [LANES*DATA_WIDTH-1:0]   a_vec,
    input  logic [LANES*DATA_WIDTH-1:0]   b_vec,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [LANES*ACC_WIDTH-1:0]    cout,
    output logic [LANES-1:0]              ovf
);

    localparam int unsigned ProdW = 2 * DATA_WIDTH;
    localparam int unsigned SumW  = ACC_WIDTH + 1;
    localparam int unsigned CntW  = $clog2(VEC_LEN + 1);

    localparam logic [CntW-1:0] CntLast = CntW'(VEC_LEN);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StAcc   = 2'd1;
    localparam logic [1:0] StDrain = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    logic [1:0]                 state_q, state_d;
    logic [CntW-1:0]            cnt_q, cnt_d;
    logic [LANES*ProdW-1:0]     prod_q, prod_d;
    logic                       pend_q, pend_d;   // product register holds an unadded beat
    logic [LANES*ACC_WIDTH-1:0] acc_q, acc_d;
    logic [LANES-1:0]           ovf_q, ovf_d;

    logic                       accept;
    logic [CntW-1:0]            cnt_inc;
    logic [LANES*ProdW-1:0]     prod_new;
    logic [LANES*ACC_WIDTH-1:0] acc_upd;
    logic [LANES-1:0]           ovf_upd;
    logic [SumW-1:0]            sum;

    assign in_ready  = (state_q == StIdle) || (state_q == StAcc);
    assign out_valid = (state_q == StDone);
    assign accept    = in_valid && in_ready;
    assign cnt_inc   = cnt_q + CntW'(1);
    assign cout      = acc_q;
    assign ovf       = ovf_q;

    // Lane products, zero-extended into the 2*DATA_WIDTH product register.
    always_comb begin
        prod_new = '0;
        for (int i = 0; i < LANES; i++) begin
            prod_new[i*ProdW +: ProdW] = ProdW'(a_vec[i*DATA_WIDTH +: DATA_WIDTH])
                                       * ProdW'(b_vec[i*DATA_WIDTH +: DATA_WIDTH]);
        end
    end

    // Per-lane accumulate, one bit wider than the accumulator to expose carry-out.
    always_comb begin
        acc_upd = acc_q;
        ovf_upd = ovf_q;
        sum     = '0;
        for (int i = 0; i < LANES; i++) begin
            sum = {1'b0, acc_q[i*ACC_WIDTH +: ACC_WIDTH]} + SumW'(prod_q[i*ProdW +: ProdW]);
`ifdef MAC_ARRAY_SAT_EN
            // Once a lane has saturated it stays pinned until the operation ends.
            if (sum[ACC_WIDTH] || ovf_q[i]) begin
                acc_upd[i*ACC_WIDTH +: ACC_WIDTH] = '1;
                ovf_upd[i]                        = 1'b1;
            end else begin
                acc_upd[i*ACC_WIDTH +: ACC_WIDTH] = sum[ACC_WIDTH-1:0];
            end
`else
            acc_upd[i*ACC_WIDTH +: ACC_WIDTH] = sum[ACC_WIDTH-1:0];
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        pend_d  = accept;
        acc_d   = acc_q;
        ovf_d   = ovf_q;

        if (accept) begin
            prod_d = prod_new;
            cnt_d  = cnt_inc;
        end
        if (pend_q) begin
            acc_d = acc_upd;
            ovf_d = ovf_upd;
        end

        case (state_q)
            StIdle, StAcc: begin
                if (accept) begin
                    state_d = (cnt_inc == CntLast) ? StDrain : StAcc;
                end
            end
            StDrain: state_d = StDone;
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    prod_d  = '0;
                    pend_d  = 1'b0;
                    acc_d   = '0;
                    ovf_d   = '0;
                end
            end
            default: state_d = StIdle;
        endcase

        // Clear wins over any handshake in the same cycle; a concurrent beat is dropped.
        if (clr) begin
            state_d = StIdle;
            cnt_d   = '0;
            prod_d  = '0;
            pend_d  = 1'b0;
            acc_d   = '0;
            ovf_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            prod_q  <= '0;
            pend_q  <= 1'b0;
            acc_q   <= '0;
            ovf_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            pend_q  <= pend_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule
